// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, memory wait, HALT drain.
// Optional stall counter enabled with `define PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_halt,
  input  logic [2:0] ex_rd,
  input  logic       ex_memread,
  input  logic       mem_branch,
  input  logic       mem_busy,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       exmem_flush,
  output logic       memwb_en,
  output logic       halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } ctrl_t;

  localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [1:0] drain_cnt;
  ctrl_t      ctrl;
  logic       load_use;

  assign load_use = ex_memread &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  always_comb begin
    ctrl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
             idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1};
    if (rst) begin
      ctrl = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0,
               idex_flush: 1'b1, exmem_en: 1'b0, exmem_flush: 1'b1, memwb_en: 1'b0};
    end else if (state == HALTED || mem_busy) begin
      ctrl = '0;
    end else if (mem_branch) begin
      // PC takes the branch target; everything younger than MEM is wrong-path.
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
    end else if (state == DRAIN) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_en    = 1'b0;
      ctrl.idex_flush = 1'b1;
    end else if (id_halt) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_flush = 1'b1;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_en    = ctrl.memwb_en;
  assign halted      = (state == HALTED) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else if (!mem_busy) begin
      case (state)
        RUN: begin
          if (!mem_branch && !load_use && id_halt) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          // A taken branch ahead of the HALT means the HALT was fetched down the wrong path.
          if (mem_branch) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
          end else if (drain_cnt == 2'd0) begin
            state <= HALTED;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (!pc_en && state != HALTED && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences, random vs. reference model.
module tb_pipe_hazard_ctrl;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst, id_uses_rs, id_uses_rt, id_halt, ex_memread, mem_branch, mem_busy;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_halt(id_halt), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_branch(mem_branch), .mem_busy(mem_busy), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en), .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // {halted, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}
  localparam logic [8:0] V_IDLE   = 9'b0_11010101;
  localparam logic [8:0] V_RESET  = 9'b0_00101010;
  localparam logic [8:0] V_BUSY   = 9'b0_00000000;
  localparam logic [8:0] V_BRANCH = 9'b0_11111111;
  localparam logic [8:0] V_LDUSE  = 9'b0_00011101;
  localparam logic [8:0] V_HALT   = 9'b0_01110101;
  localparam logic [8:0] V_DRAIN  = 9'b0_01111101;
  localparam logic [8:0] V_HALTED = 9'b1_00000000;

  function automatic logic [8:0] obs();
    return {halted, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic [2:0] rs, input logic [2:0] rt, input logic urs,
                        input logic urt, input logic hlt, input logic [2:0] rd, input logic mr,
                        input logic br, input logic bz);
    rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt; id_halt = hlt;
    ex_rd = rd; ex_memread = mr; mem_branch = br; mem_busy = bz;
  endtask

  task automatic idle();
    set_in(0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // Reference model: mode 0=running, 1=draining, 2=halted; 'left' = drain cycles still owed.
  int mode, left;
  int unsigned mcnt;

  function automatic logic [8:0] model_out(input int m);
    logic lu;
    lu = ex_memread && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (rst)             return V_RESET;
    if (m == 2)          return V_HALTED;
    if (mem_busy)        return V_BUSY;
    if (mem_branch)      return V_BRANCH;
    if (m == 1)          return V_DRAIN;
    if (lu)              return V_LDUSE;
    if (id_halt)         return V_HALT;
    return V_IDLE;
  endfunction

  task automatic model_step();
    logic [8:0] o;
    logic lu;
    o  = model_out(mode);
    lu = ex_memread && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (rst) begin
      mode = 0; left = 0; mcnt = 0;
    end else begin
      if (o[7] == 1'b0 && mode != 2 && mcnt < (2**CNT_W) - 1) mcnt++;
      if (mode == 2 || mem_busy) ;
      else if (mem_branch) begin mode = 0; left = 0; end
      else if (mode == 1) begin
        if (left == 1) mode = 2; else left--;
      end
      else if (!lu && id_halt) begin mode = 1; left = DRAIN_CYCLES; end
    end
  endtask

  typedef struct {
    string      name;
    logic       r;
    logic [2:0] rs, rt;
    logic       urs, urt, hlt;
    logic [2:0] rd;
    logic       mr, br, bz;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{"idle",          0, 3'd1, 3'd2, 1, 1, 0, 3'd3, 1, 0, 0, V_IDLE};
    tbl[1]  = '{"reset",         1, 3'd1, 3'd2, 1, 1, 0, 3'd1, 1, 0, 0, V_RESET};
    tbl[2]  = '{"reset_busy",    1, 3'd0, 3'd0, 0, 0, 1, 3'd0, 0, 1, 1, V_RESET};
    tbl[3]  = '{"busy",          0, 3'd1, 3'd2, 1, 1, 0, 3'd1, 1, 1, 1, V_BUSY};
    tbl[4]  = '{"branch",        0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, V_BRANCH};
    tbl[5]  = '{"ldu_rs",        0, 3'd1, 3'd3, 1, 1, 0, 3'd1, 1, 0, 0, V_LDUSE};
    tbl[6]  = '{"ldu_rt",        0, 3'd4, 3'd7, 1, 1, 0, 3'd7, 1, 0, 0, V_LDUSE};
    tbl[7]  = '{"rs_unused",     0, 3'd5, 3'd2, 0, 1, 0, 3'd5, 1, 0, 0, V_IDLE};
    tbl[8]  = '{"rd_differs",    0, 3'd5, 3'd2, 1, 1, 0, 3'd6, 1, 0, 0, V_IDLE};
    tbl[9]  = '{"no_load",       0, 3'd5, 3'd5, 1, 1, 0, 3'd5, 0, 0, 0, V_IDLE};
    tbl[10] = '{"halt",          0, 3'd0, 3'd0, 0, 0, 1, 3'd0, 0, 0, 0, V_HALT};
    tbl[11] = '{"halt_ldu",      0, 3'd2, 3'd0, 1, 0, 1, 3'd2, 1, 0, 0, V_LDUSE};
    tbl[12] = '{"branch_ldu",    0, 3'd2, 3'd0, 1, 0, 1, 3'd2, 1, 1, 0, V_BRANCH};
    tbl[13] = '{"busy_branch",   0, 3'd0, 3'd0, 0, 0, 1, 3'd0, 0, 1, 1, V_BUSY};

    idle(); rst = 1'b1; #1;
    for (int i = 0; i < 14; i++) begin
      do_reset();
      set_in(tbl[i].r, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].hlt,
             tbl[i].rd, tbl[i].mr, tbl[i].br, tbl[i].bz);
      #1 chk(tbl[i].name, obs(), tbl[i].exp);
    end

    // Load-use: one bubble, then ADD moves into EX and the stall clears.
    do_reset();
    set_in(0, 3'd1, 3'd3, 1, 1, 0, 3'd1, 1, 0, 0);
    #1 chk("ldu_bubble", obs(), V_LDUSE);
    tick();
    set_in(0, 3'd4, 3'd5, 1, 1, 0, 3'd2, 0, 0, 0);
    #1 chk("ldu_release", obs(), V_IDLE);

    // HALT then idle: halted appears DRAIN_CYCLES+1 clocks later.
    do_reset();
    id_halt = 1'b1;
    #1 chk("halt_issue", obs(), V_HALT);
    tick(); idle();
    for (int k = 0; k < DRAIN_CYCLES; k++) begin
      #1 chk($sformatf("drain_%0d", k), obs(), V_DRAIN);
      tick();
    end
    #1 chk("halted", obs(), V_HALTED);
    tick(); set_in(0, 3'd1, 3'd1, 1, 1, 0, 3'd1, 1, 1, 0);
    #1 chk("halted_sticky", obs(), V_HALTED);

`ifdef PIPE_CTRL_PERF_EN
    compared++;
    if (stall_cnt !== CNT_W'(DRAIN_CYCLES + 1)) begin
      mismatched++;
      $display("FAIL stall_cnt_halt: got %0d expected %0d", stall_cnt, DRAIN_CYCLES + 1);
    end
`endif

    // Reset out of HALTED.
    rst = 1'b1;
    #1 chk("rst_in_halted", obs(), V_RESET);
    tick(); idle();
    #1 chk("after_rst", obs(), V_IDLE);
`ifdef PIPE_CTRL_PERF_EN
    compared++;
    if (stall_cnt !== '0) begin
      mismatched++;
      $display("FAIL stall_cnt_rst: got %0d expected 0", stall_cnt);
    end
`endif

    // Wrong-path HALT: branch while draining returns to RUN.
    do_reset();
    id_halt = 1'b1; tick(); idle();
    mem_branch = 1'b1;
    #1 chk("drain_branch", obs(), V_BRANCH);
    tick(); idle();
    #1 chk("drain_branch_run", obs(), V_IDLE);

    // Memory wait during DRAIN delays halted by the busy cycles.
    do_reset();
    id_halt = 1'b1; tick(); idle();
    #1 chk("busy_drain0", obs(), V_DRAIN);
    tick();
    mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("busy_hold_%0d", k), obs(), V_BUSY);
      tick();
    end
    mem_busy = 1'b0;
    for (int k = 1; k < DRAIN_CYCLES; k++) begin
      #1 chk($sformatf("busy_drain%0d", k), obs(), V_DRAIN);
      tick();
    end
    #1 chk("busy_halted", obs(), V_HALTED);

    // Randomized run against the reference model.
    do_reset();
    mode = 0; left = 0; mcnt = 0;
    for (int c = 0; c < 4000; c++) begin
      set_in($urandom_range(0, 99) < 3, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), $urandom_range(0, 99) < 8, 3'($urandom_range(0, 3)),
             $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
      #1 chk($sformatf("rand_%0d", c), obs(), model_out(mode));
`ifdef PIPE_CTRL_PERF_EN
      compared++;
      if (stall_cnt !== CNT_W'(mcnt)) begin
        mismatched++;
        $display("FAIL rand_cnt_%0d: got %0d expected %0d", c, stall_cnt, mcnt);
      end
`endif
      model_step();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
